// File: rtl/shift_reg_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_pwr_pkg
// Purpose  : Shared mode encodings and sizing helper for shift_reg_pwr.
// Revision : 1.0 - initial release
// ============================================================================
package shift_reg_pwr_pkg;

    typedef enum logic [1:0] {
        PUSH  = 2'b00,
        CYCLE = 2'b01,
        LOAD  = 2'b10,
        HOLD  = 2'b11
    } mode_e;

    // Per-edge toggle count spans 0..n+1 (all Q bits plus S_OUT).
    function automatic int toggle_w(input int n);
        return $clog2(n + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg_pwr_pwr_toggle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : pwr_toggle_cnt
// Purpose  : Counts Q/S_OUT bit toggles per edge into a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module pwr_toggle_cnt
    import shift_reg_pwr_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_enb,
    input  logic             i_cnt_clr,
    input  logic [N-1:0]     i_q_old,
    input  logic [N-1:0]     i_q_new,
    input  logic             i_s_old,
    input  logic             i_s_new,
    output logic [CNT_W-1:0] o_pwr_cnt
);

    localparam int              c_T_W     = toggle_w(N);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [N-1:0]     w_diff;
    logic [c_T_W-1:0] w_t;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_diff = i_q_old ^ i_q_new;
        w_t    = c_T_W'(i_s_old ^ i_s_new);
        for (int i = 0; i < N; i++) begin
            w_t = w_t + c_T_W'(w_diff[i]);
        end
        w_sum = {1'b0, r_cnt} + (CNT_W + 1)'(w_t);
    end

    always_ff @(posedge CLK) begin
        if (RESET || i_cnt_clr) begin
            r_cnt <= '0;
        end else if (i_enb) begin
            r_cnt <= w_sum[CNT_W] ? c_CNT_MAX : w_sum[CNT_W-1:0];
        end
    end

    assign o_pwr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/shift_reg_pwr.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_pwr
// Purpose  : Universal N-bit shift register with saturating toggle counter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_pwr
    import shift_reg_pwr_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic             DIR,
    input  logic [N-1:0]     D,
    input  logic             S_IN,
    input  logic             CNT_CLR,
    output logic [N-1:0]     Q,
    output logic             S_OUT,
    output logic [CNT_W-1:0] PWR_CNT
);

    logic [N-1:0] r_q;
    logic         r_s_out;
    logic [N-1:0] w_q_next;
    logic         w_s_next;
    logic [N-1:0] w_push_l;
    logic [N-1:0] w_push_r;
    logic [N-1:0] w_rot_l;
    logic [N-1:0] w_rot_r;
    mode_e        w_mode;

    // A one-bit register has no interior bits: push replaces it, rotate keeps it.
    if (N > 1) begin : g_wide
        assign w_push_l = {r_q[N-2:0], S_IN};
        assign w_push_r = {S_IN, r_q[N-1:1]};
        assign w_rot_l  = {r_q[N-2:0], r_q[N-1]};
        assign w_rot_r  = {r_q[0], r_q[N-1:1]};
    end else begin : g_narrow
        assign w_push_l = S_IN;
        assign w_push_r = S_IN;
        assign w_rot_l  = r_q;
        assign w_rot_r  = r_q;
    end

    assign w_mode = mode_e'(MODO);

    always_comb begin
        w_q_next = r_q;
        w_s_next = r_s_out;
        if (ENB) begin
            case (w_mode)
                LOAD: begin
                    w_q_next = D;
                    w_s_next = 1'b0;
                end
                PUSH: begin
                    w_q_next = DIR ? w_push_r : w_push_l;
                    w_s_next = DIR ? r_q[0] : r_q[N-1];
                end
                CYCLE: begin
                    w_q_next = DIR ? w_rot_r : w_rot_l;
                    w_s_next = DIR ? r_q[0] : r_q[N-1];
                end
                default: begin
                    w_q_next = r_q;
                    w_s_next = r_s_out;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_q     <= '0;
            r_s_out <= 1'b0;
        end else begin
            r_q     <= w_q_next;
            r_s_out <= w_s_next;
        end
    end

    pwr_toggle_cnt #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_pwr_toggle_cnt (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_enb     (ENB),
        .i_cnt_clr (CNT_CLR),
        .i_q_old   (r_q),
        .i_q_new   (w_q_next),
        .i_s_old   (r_s_out),
        .i_s_new   (w_s_next),
        .o_pwr_cnt (PWR_CNT)
    );

    assign Q     = r_q;
    assign S_OUT = r_s_out;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_pwr.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_pwr
// Purpose  : Directed self-checking bench for shift_reg_pwr (N=4, N=1, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_reg_pwr;

    localparam logic [1:0] c_PUSH  = 2'b00;
    localparam logic [1:0] c_CYCLE = 2'b01;
    localparam logic [1:0] c_LOAD  = 2'b10;
    localparam logic [1:0] c_HOLD  = 2'b11;

    logic        CLK;
    logic        RESET;
    logic        ENB;
    logic [1:0]  MODO;
    logic        DIR;
    logic [3:0]  D;
    logic        S_IN;
    logic        CNT_CLR;

    logic [3:0]  q;
    logic        s_out;
    logic [31:0] pwr_cnt;
    logic [3:0]  q_sat;
    logic        s_out_sat;
    logic [3:0]  pwr_cnt_sat;
    logic        q1;
    logic        s_out1;
    logic [31:0] pwr_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    shift_reg_pwr #(.N(4), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .DIR(DIR), .D(D),
        .S_IN(S_IN), .CNT_CLR(CNT_CLR), .Q(q), .S_OUT(s_out), .PWR_CNT(pwr_cnt)
    );

    shift_reg_pwr #(.N(4), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .DIR(DIR), .D(D),
        .S_IN(S_IN), .CNT_CLR(CNT_CLR), .Q(q_sat), .S_OUT(s_out_sat), .PWR_CNT(pwr_cnt_sat)
    );

    shift_reg_pwr #(.N(1), .CNT_W(32)) dut_n1 (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .DIR(DIR), .D(D[0]),
        .S_IN(S_IN), .CNT_CLR(CNT_CLR), .Q(q1), .S_OUT(s_out1), .PWR_CNT(pwr_cnt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [3:0] eq, input logic es, input logic [31:0] ep);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".s_out"}, 32'(s_out), 32'(es));
        chk({tag, ".pwr"}, pwr_cnt, ep);
    endtask

    task automatic chk_n1(input string tag, input logic eq, input logic es, input logic [31:0] ep);
        chk({tag, ".q"}, 32'(q1), 32'(eq));
        chk({tag, ".s_out"}, 32'(s_out1), 32'(es));
        chk({tag, ".pwr"}, pwr_cnt1, ep);
    endtask

    task automatic step(input logic rst, input logic enb, input logic [1:0] mode,
                        input logic dir, input logic [3:0] d, input logic sin, input logic clr);
        RESET   = rst;
        ENB     = enb;
        MODO    = mode;
        DIR     = dir;
        D       = d;
        S_IN    = sin;
        CNT_CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1; ENB = 1'b0; MODO = c_HOLD; DIR = 1'b0; D = 4'h0; S_IN = 1'b0; CNT_CLR = 1'b0;
        #2;

        step(1, 0, c_HOLD, 0, 4'h0, 0, 0);
        chk_main("reset", 4'b0000, 0, 0);

        step(0, 1, c_LOAD, 0, 4'b1101, 1, 0);
        chk_main("load1101", 4'b1101, 0, 3);

        step(0, 1, c_PUSH, 0, 4'h0, 0, 0);
        chk_main("pushl1", 4'b1010, 1, 7);
        step(0, 1, c_PUSH, 0, 4'h0, 0, 0);
        chk_main("pushl2", 4'b0100, 1, 10);

        step(0, 1, c_LOAD, 0, 4'b0000, 0, 0);
        chk_main("load0000", 4'b0000, 0, 12);
        step(0, 1, c_PUSH, 1, 4'h0, 1, 0);
        chk_main("pushr1", 4'b1000, 0, 13);
        step(0, 1, c_PUSH, 1, 4'h0, 1, 0);
        chk_main("pushr2", 4'b1100, 0, 14);
        step(0, 1, c_PUSH, 1, 4'h0, 1, 0);
        chk_main("pushr3", 4'b1110, 0, 15);
        step(0, 1, c_PUSH, 1, 4'h0, 1, 0);
        chk_main("pushr4", 4'b1111, 0, 16);

        step(0, 1, c_LOAD, 1, 4'b1010, 1, 0);
        chk_main("load1010", 4'b1010, 0, 18);
        step(0, 1, c_CYCLE, 0, 4'h0, 0, 0);
        chk_main("cycl", 4'b0101, 1, 23);
        step(0, 1, c_LOAD, 0, 4'b0110, 0, 0);
        chk_main("load0110", 4'b0110, 0, 26);
        step(0, 1, c_CYCLE, 1, 4'h0, 0, 0);
        chk_main("cycr", 4'b0011, 0, 28);

        for (int i = 0; i < 5; i++) begin
            step(0, 0, 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), 1'($urandom), 0);
            chk_main("enb0", 4'b0011, 0, 28);
        end

        step(0, 1, c_HOLD, 0, 4'hF, 1, 0);
        chk_main("hold", 4'b0011, 0, 28);

        step(0, 1, c_PUSH, 0, 4'h0, 1, 1);
        chk_main("clr_push", 4'b0111, 0, 0);
        step(0, 1, c_PUSH, 0, 4'h0, 0, 0);
        chk_main("after_clr", 4'b1110, 0, 2);
        step(0, 0, c_PUSH, 0, 4'h0, 1, 1);
        chk_main("clr_enb0", 4'b1110, 0, 0);
        step(0, 1, c_LOAD, 0, 4'b1001, 0, 0);
        chk_main("load1001", 4'b1001, 0, 3);
        step(1, 1, c_CYCLE, 0, 4'h0, 0, 1);
        chk_main("rst_cycle", 4'b0000, 0, 0);

        // Alternating full loads add 4 per edge; the 4-bit counter clips at 15.
        for (int k = 1; k <= 6; k++) begin
            step(0, 1, c_LOAD, 0, (k % 2 == 1) ? 4'b1111 : 4'b0000, 0, 0);
            chk("sat.cnt", 32'(pwr_cnt_sat), (4 * k > 15) ? 32'd15 : 32'(4 * k));
        end
        chk_main("sat.wide", 4'b0000, 0, 24);
        step(0, 1, c_LOAD, 0, 4'b1111, 0, 0);
        chk("sat.hold", 32'(pwr_cnt_sat), 32'd15);
        step(0, 1, c_HOLD, 0, 4'h0, 0, 1);
        chk("sat.clr", 32'(pwr_cnt_sat), 32'd0);

        step(1, 1, c_LOAD, 0, 4'h1, 0, 0);
        chk_n1("n1.reset", 0, 0, 0);
        step(0, 1, c_LOAD, 0, 4'h1, 0, 0);
        chk_n1("n1.load", 1, 0, 1);
        step(0, 1, c_CYCLE, 0, 4'h0, 0, 0);
        chk_n1("n1.cycl", 1, 1, 2);
        step(0, 1, c_CYCLE, 1, 4'h0, 0, 0);
        chk_n1("n1.cycr", 1, 1, 2);
        step(0, 1, c_PUSH, 1, 4'h0, 0, 0);
        chk_n1("n1.pushr", 0, 1, 3);
        step(0, 1, c_PUSH, 0, 4'h0, 1, 0);
        chk_n1("n1.pushl", 1, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
